// File: rtl/tcp_pkg.sv
// Shared TCP flow-state definitions: field widths and the read-modify-write FSM encoding.
package tcp_pkg;

    localparam int FLOWID_W    = 8;
    localparam int TCP_STATE_W = 64;

    typedef enum logic [2:0] {
        RMW_IDLE    = 3'd0,
        RMW_RD_REQ  = 3'd1,
        RMW_RD_RESP = 3'd2,
        RMW_WR_REQ  = 3'd3,
        RMW_RESP    = 3'd4
    } rmw_state_e;

endpackage

// File: rtl/tcp_state_rmw_engine_if.sv
// Update request/response channel between a client (master) and the RMW engine (slave).
interface tcp_state_rmw_engine_if #(
    parameter int width_p = tcp_pkg::TCP_STATE_W
) ();
    import tcp_pkg::*;

    logic                upd_req_val;
    logic [FLOWID_W-1:0] upd_req_flowid;
    logic [width_p-1:0]  upd_req_mask;
    logic [width_p-1:0]  upd_req_data;
    logic                upd_req_rdy;

    logic                upd_resp_val;
    logic                upd_resp_rdy;
    logic [FLOWID_W-1:0] upd_resp_flowid;
    logic [width_p-1:0]  upd_resp_old_state;
    logic [width_p-1:0]  upd_resp_new_state;

    modport master (
        output upd_req_val, upd_req_flowid, upd_req_mask, upd_req_data,
        input  upd_req_rdy,
        input  upd_resp_val, upd_resp_flowid, upd_resp_old_state, upd_resp_new_state,
        output upd_resp_rdy
    );

    modport slave (
        input  upd_req_val, upd_req_flowid, upd_req_mask, upd_req_data,
        output upd_req_rdy,
        output upd_resp_val, upd_resp_flowid, upd_resp_old_state, upd_resp_new_state,
        input  upd_resp_rdy
    );

endinterface

// File: rtl/tcp_state_rmw_engine.sv
// Masked read-modify-write of one flow-state word in the external store, one update in flight.
module tcp_state_rmw_engine
    import tcp_pkg::*;
#(
    parameter int width_p = TCP_STATE_W
) (
    input  logic                clk,
    input  logic                rst,
    tcp_state_rmw_engine_if.slave upd,
    output logic                rmw_tcp_state_rd_req_val,
    output logic [FLOWID_W-1:0] rmw_tcp_state_rd_req_addr,
    input  logic                tcp_state_rmw_rd_req_rdy,
    input  logic                tcp_state_rmw_rd_resp_val,
    input  logic [width_p-1:0]  tcp_state_rmw_rd_resp_state,
    output logic                rmw_tcp_state_rd_resp_rdy,
    output logic                rmw_tcp_state_wr_req_val,
    output logic [FLOWID_W-1:0] rmw_tcp_state_wr_req_addr,
    output logic [width_p-1:0]  rmw_tcp_state_wr_req_state,
    input  logic                tcp_state_rmw_wr_req_rdy
);

    rmw_state_e          state_r;
    logic                req_rdy_r;
    logic                rd_req_val_r;
    logic                rd_resp_rdy_r;
    logic                wr_req_val_r;
    logic                resp_val_r;
    logic [FLOWID_W-1:0] flowid_r;
    logic [width_p-1:0]  mask_r;
    logic [width_p-1:0]  data_r;
    logic [width_p-1:0]  old_r;
    logic [width_p-1:0]  new_r;

    // Purely bitwise merge: masked bits come from data, the rest keep the old value.
    function automatic logic [width_p-1:0] merge_state(
        input logic [width_p-1:0] old_s,
        input logic [width_p-1:0] mask_s,
        input logic [width_p-1:0] data_s
    );
        return (old_s & ~mask_s) | (data_s & mask_s);
    endfunction

    // FSM with registered handshake outputs; each flag is set on entry to its state and cleared on exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= RMW_IDLE;
            req_rdy_r     <= 1'b1;
            rd_req_val_r  <= 1'b0;
            rd_resp_rdy_r <= 1'b0;
            wr_req_val_r  <= 1'b0;
            resp_val_r    <= 1'b0;
            flowid_r      <= {FLOWID_W{1'b0}};
            mask_r        <= {width_p{1'b0}};
            data_r        <= {width_p{1'b0}};
            old_r         <= {width_p{1'b0}};
            new_r         <= {width_p{1'b0}};
        end else begin
            case (state_r)
                RMW_IDLE: begin
                    if (upd.upd_req_val && req_rdy_r) begin
                        flowid_r     <= upd.upd_req_flowid;
                        mask_r       <= upd.upd_req_mask;
                        data_r       <= upd.upd_req_data;
                        req_rdy_r    <= 1'b0;
                        rd_req_val_r <= 1'b1;
                        state_r      <= RMW_RD_REQ;
                    end
                end
                RMW_RD_REQ: begin
                    if (tcp_state_rmw_rd_req_rdy) begin
                        rd_req_val_r  <= 1'b0;
                        rd_resp_rdy_r <= 1'b1;
                        state_r       <= RMW_RD_RESP;
                    end
                end
                RMW_RD_RESP: begin
                    if (tcp_state_rmw_rd_resp_val) begin
                        old_r         <= tcp_state_rmw_rd_resp_state;
                        new_r         <= merge_state(tcp_state_rmw_rd_resp_state, mask_r, data_r);
                        rd_resp_rdy_r <= 1'b0;
                        wr_req_val_r  <= 1'b1;
                        state_r       <= RMW_WR_REQ;
                    end
                end
                RMW_WR_REQ: begin
                    // The response is held back until the store has committed the write.
                    if (tcp_state_rmw_wr_req_rdy) begin
                        wr_req_val_r <= 1'b0;
                        resp_val_r   <= 1'b1;
                        state_r      <= RMW_RESP;
                    end
                end
                RMW_RESP: begin
                    if (upd.upd_resp_rdy) begin
                        resp_val_r <= 1'b0;
                        req_rdy_r  <= 1'b1;
                        state_r    <= RMW_IDLE;
                    end
                end
                default: begin
                    state_r       <= RMW_IDLE;
                    req_rdy_r     <= 1'b1;
                    rd_req_val_r  <= 1'b0;
                    rd_resp_rdy_r <= 1'b0;
                    wr_req_val_r  <= 1'b0;
                    resp_val_r    <= 1'b0;
                end
            endcase
        end
    end

    assign upd.upd_req_rdy            = req_rdy_r;
    assign upd.upd_resp_val           = resp_val_r;
    assign upd.upd_resp_flowid        = flowid_r;
    assign upd.upd_resp_old_state     = old_r;
    assign upd.upd_resp_new_state     = new_r;
    assign rmw_tcp_state_rd_req_val   = rd_req_val_r;
    assign rmw_tcp_state_rd_req_addr  = flowid_r;
    assign rmw_tcp_state_rd_resp_rdy  = rd_resp_rdy_r;
    assign rmw_tcp_state_wr_req_val   = wr_req_val_r;
    assign rmw_tcp_state_wr_req_addr  = flowid_r;
    assign rmw_tcp_state_wr_req_state = new_r;

endmodule

// File: tb/tb_tcp_state_rmw_engine.sv
// Directed bench for tcp_state_rmw_engine at width_p=16 with a small flow-state store model.
module tb_tcp_state_rmw_engine;
    import tcp_pkg::*;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                rmw_tcp_state_rd_req_val;
    logic [FLOWID_W-1:0] rmw_tcp_state_rd_req_addr;
    logic                tcp_state_rmw_rd_req_rdy = 1'b0;
    logic                tcp_state_rmw_rd_resp_val = 1'b0;
    logic [15:0]         tcp_state_rmw_rd_resp_state = 16'h0000;
    logic                rmw_tcp_state_rd_resp_rdy;
    logic                rmw_tcp_state_wr_req_val;
    logic [FLOWID_W-1:0] rmw_tcp_state_wr_req_addr;
    logic [15:0]         rmw_tcp_state_wr_req_state;
    logic                tcp_state_rmw_wr_req_rdy = 1'b0;

    logic [15:0] store_mem [0:15];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    tcp_state_rmw_engine_if #(.width_p(16)) upd_if ();

    tcp_state_rmw_engine #(.width_p(16)) dut (
        .clk                         (clk),
        .rst                         (rst),
        .upd                         (upd_if),
        .rmw_tcp_state_rd_req_val    (rmw_tcp_state_rd_req_val),
        .rmw_tcp_state_rd_req_addr   (rmw_tcp_state_rd_req_addr),
        .tcp_state_rmw_rd_req_rdy    (tcp_state_rmw_rd_req_rdy),
        .tcp_state_rmw_rd_resp_val   (tcp_state_rmw_rd_resp_val),
        .tcp_state_rmw_rd_resp_state (tcp_state_rmw_rd_resp_state),
        .rmw_tcp_state_rd_resp_rdy   (rmw_tcp_state_rd_resp_rdy),
        .rmw_tcp_state_wr_req_val    (rmw_tcp_state_wr_req_val),
        .rmw_tcp_state_wr_req_addr   (rmw_tcp_state_wr_req_addr),
        .rmw_tcp_state_wr_req_state  (rmw_tcp_state_wr_req_state),
        .tcp_state_rmw_wr_req_rdy    (tcp_state_rmw_wr_req_rdy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete update with the store model answering; stall counts delay each handshake.
    task automatic run_update(input logic [3:0] flow, input logic [15:0] mask, input logic [15:0] data,
                              input int rs, input int ps, input int ws, input int us, input bit chk_lat,
                              input logic [15:0] exp_old, input logic [15:0] exp_new);
        int t0;
        logic [FLOWID_W-1:0] waddr;
        logic [15:0] wstate;
        chk("idle_req_rdy", upd_if.upd_req_rdy, 32'd1);
        upd_if.upd_req_val    = 1'b1;
        upd_if.upd_req_flowid = {4'h0, flow};
        upd_if.upd_req_mask   = mask;
        upd_if.upd_req_data   = data;
        t0 = cyc;
        step();
        upd_if.upd_req_val  = 1'b0;
        upd_if.upd_req_mask = 16'h5A5A;
        upd_if.upd_req_data = 16'hA5A5;
        chk("rd_req_val", rmw_tcp_state_rd_req_val, 32'd1);
        chk("rd_req_addr", rmw_tcp_state_rd_req_addr, {28'h0, flow});
        chk("busy_req_rdy", upd_if.upd_req_rdy, 32'd0);
        for (int i = 0; i < rs; i++) begin
            step();
            chk("rd_req_val_stall", rmw_tcp_state_rd_req_val, 32'd1);
            chk("rd_req_addr_stall", rmw_tcp_state_rd_req_addr, {28'h0, flow});
        end
        tcp_state_rmw_rd_req_rdy = 1'b1;
        step();
        tcp_state_rmw_rd_req_rdy = 1'b0;
        chk("rd_resp_rdy", rmw_tcp_state_rd_resp_rdy, 32'd1);
        chk("rd_req_val_done", rmw_tcp_state_rd_req_val, 32'd0);
        for (int i = 0; i < ps; i++) begin
            step();
            chk("rd_resp_rdy_stall", rmw_tcp_state_rd_resp_rdy, 32'd1);
            chk("wr_val_early", rmw_tcp_state_wr_req_val, 32'd0);
        end
        tcp_state_rmw_rd_resp_val   = 1'b1;
        tcp_state_rmw_rd_resp_state = store_mem[flow];
        step();
        tcp_state_rmw_rd_resp_val   = 1'b0;
        tcp_state_rmw_rd_resp_state = 16'hDEAD;
        chk("rd_resp_rdy_done", rmw_tcp_state_rd_resp_rdy, 32'd0);
        chk("wr_req_val", rmw_tcp_state_wr_req_val, 32'd1);
        chk("wr_req_addr", rmw_tcp_state_wr_req_addr, {28'h0, flow});
        chk("wr_req_state", rmw_tcp_state_wr_req_state, {16'h0, exp_new});
        for (int i = 0; i < ws; i++) begin
            step();
            chk("wr_req_val_stall", rmw_tcp_state_wr_req_val, 32'd1);
            chk("wr_req_state_stall", rmw_tcp_state_wr_req_state, {16'h0, exp_new});
            chk("resp_val_early", upd_if.upd_resp_val, 32'd0);
        end
        tcp_state_rmw_wr_req_rdy = 1'b1;
        waddr  = rmw_tcp_state_wr_req_addr;
        wstate = rmw_tcp_state_wr_req_state;
        step();
        tcp_state_rmw_wr_req_rdy = 1'b0;
        store_mem[waddr[3:0]] = wstate;
        chk("resp_val", upd_if.upd_resp_val, 32'd1);
        chk("wr_req_val_done", rmw_tcp_state_wr_req_val, 32'd0);
        chk("resp_flowid", upd_if.upd_resp_flowid, {28'h0, flow});
        chk("resp_old", upd_if.upd_resp_old_state, {16'h0, exp_old});
        chk("resp_new", upd_if.upd_resp_new_state, {16'h0, exp_new});
        if (chk_lat) chk("resp_latency", cyc - t0, 32'd4);
        for (int i = 0; i < us; i++) begin
            step();
            chk("resp_val_stall", upd_if.upd_resp_val, 32'd1);
            chk("resp_old_stall", upd_if.upd_resp_old_state, {16'h0, exp_old});
            chk("resp_new_stall", upd_if.upd_resp_new_state, {16'h0, exp_new});
        end
        upd_if.upd_resp_rdy = 1'b1;
        step();
        upd_if.upd_resp_rdy = 1'b0;
        chk("resp_val_done", upd_if.upd_resp_val, 32'd0);
        chk("req_rdy_back", upd_if.upd_req_rdy, 32'd1);
    endtask

    initial begin
        upd_if.upd_req_val    = 1'b0;
        upd_if.upd_req_flowid = 8'h00;
        upd_if.upd_req_mask   = 16'h0000;
        upd_if.upd_req_data   = 16'h0000;
        upd_if.upd_resp_rdy   = 1'b0;
        for (int i = 0; i < 16; i++) store_mem[i] = 16'h0000;

        // Reset state.
        step();
        step();
        chk("rst_req_rdy", upd_if.upd_req_rdy, 32'd1);
        chk("rst_rd_val", rmw_tcp_state_rd_req_val, 32'd0);
        chk("rst_rd_resp_rdy", rmw_tcp_state_rd_resp_rdy, 32'd0);
        chk("rst_wr_val", rmw_tcp_state_wr_req_val, 32'd0);
        chk("rst_resp_val", upd_if.upd_resp_val, 32'd0);
        chk("rst_wr_state", rmw_tcp_state_wr_req_state, 32'd0);
        chk("rst_old", upd_if.upd_resp_old_state, 32'd0);
        rst = 1'b0;
        step();

        // Basic merge with minimum latency.
        store_mem[3] = 16'h00F0;
        run_update(4'd3, 16'h000F, 16'h0005, 0, 0, 0, 0, 1'b1, 16'h00F0, 16'h00F5);
        chk("store_flow3", store_mem[3], 32'h0000_00F5);

        // Back-to-back updates on one flow see the committed value.
        store_mem[7] = 16'h0000;
        run_update(4'd7, 16'h0001, 16'hFFFF, 0, 0, 0, 0, 1'b1, 16'h0000, 16'h0001);
        run_update(4'd7, 16'h0100, 16'hFFFF, 0, 0, 0, 0, 1'b1, 16'h0001, 16'h0101);
        chk("store_flow7", store_mem[7], 32'h0000_0101);

        // Stalls on every handshake.
        store_mem[3] = 16'h00F0;
        run_update(4'd3, 16'h000F, 16'h0005, $urandom_range(1, 3), $urandom_range(1, 3),
                   $urandom_range(1, 3), $urandom_range(1, 3), 1'b0, 16'h00F0, 16'h00F5);

        // Zero mask still writes, unchanged.
        store_mem[2] = 16'hBEEF;
        run_update(4'd2, 16'h0000, 16'h1234, 0, 1, 0, 0, 1'b0, 16'hBEEF, 16'hBEEF);
        chk("store_flow2", store_mem[2], 32'h0000_BEEF);

        // Bitwise merge with no carry between neighbouring bits.
        store_mem[4] = 16'h0FFF;
        run_update(4'd4, 16'h1010, 16'hFFFF, 0, 0, 1, 0, 1'b0, 16'h0FFF, 16'h1FFF);

        // Stray read response while idle is not consumed.
        tcp_state_rmw_rd_resp_val   = 1'b1;
        tcp_state_rmw_rd_resp_state = 16'hFFFF;
        step();
        chk("stray_rd_resp_rdy", rmw_tcp_state_rd_resp_rdy, 32'd0);
        chk("stray_req_rdy", upd_if.upd_req_rdy, 32'd1);
        chk("stray_wr_val", rmw_tcp_state_wr_req_val, 32'd0);
        tcp_state_rmw_rd_resp_val = 1'b0;
        step();

        // Reset while the write is stalled abandons the update.
        store_mem[5] = 16'h1234;
        upd_if.upd_req_val    = 1'b1;
        upd_if.upd_req_flowid = 8'h05;
        upd_if.upd_req_mask   = 16'hFFFF;
        upd_if.upd_req_data   = 16'hAAAA;
        step();
        upd_if.upd_req_val = 1'b0;
        tcp_state_rmw_rd_req_rdy = 1'b1;
        step();
        tcp_state_rmw_rd_req_rdy    = 1'b0;
        tcp_state_rmw_rd_resp_val   = 1'b1;
        tcp_state_rmw_rd_resp_state = store_mem[5];
        step();
        tcp_state_rmw_rd_resp_val = 1'b0;
        chk("pre_rst_wr_val", rmw_tcp_state_wr_req_val, 32'd1);
        chk("pre_rst_wr_state", rmw_tcp_state_wr_req_state, 32'h0000_AAAA);
        rst = 1'b1;
        step();
        chk("mid_rst_wr_val", rmw_tcp_state_wr_req_val, 32'd0);
        chk("mid_rst_resp_val", upd_if.upd_resp_val, 32'd0);
        chk("mid_rst_req_rdy", upd_if.upd_req_rdy, 32'd1);
        chk("mid_rst_wr_state", rmw_tcp_state_wr_req_state, 32'd0);
        chk("mid_rst_flowid", upd_if.upd_resp_flowid, 32'd0);
        rst = 1'b0;
        upd_if.upd_resp_rdy      = 1'b1;
        tcp_state_rmw_wr_req_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_resp_val", upd_if.upd_resp_val, 32'd0);
            chk("post_rst_wr_val", rmw_tcp_state_wr_req_val, 32'd0);
        end
        upd_if.upd_resp_rdy      = 1'b0;
        tcp_state_rmw_wr_req_rdy = 1'b0;

        // Flow 5 still holds its original value after the abandoned update.
        run_update(4'd5, 16'h00FF, 16'hAAAA, 0, 0, 0, 0, 1'b1, 16'h1234, 16'h12AA);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
